// File: rtl/fc_vector_loader.sv
// fc_vector_loader
// Serial-to-parallel front end for the fully-connected neuron. Each accepted
// (weight, input) beat goes into a collector slot. The bias is captured on
// element 0. When LAYER_SZ beats have been collected, the full vector set is
// copied to a registered output slot that is presented under valid/ready.
// The collector together with the output slot gives one vector of buffering.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          source beat handshake
//   in_weight/in_input         element words (SIZE bits, Q5.11 passthrough)
//   in_bias                    bias, sampled on element-0 beats only
//   in_last                    source framing marker for the final element
//   out_valid/out_ready        vector handshake toward the neuron stage
//   out_weights/out_inputs     packed vectors, element 0 in the MSBs
//   out_bias                   bias of the presented vector
//   err                        sticky framing error
module fc_vector_loader #(
    parameter int SIZE     = 16,
    parameter int LAYER_SZ = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SIZE-1:0]          in_weight,
    input  logic [SIZE-1:0]          in_input,
    input  logic [SIZE-1:0]          in_bias,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LAYER_SZ*SIZE-1:0] out_weights,
    output logic [LAYER_SZ*SIZE-1:0] out_inputs,
    output logic [SIZE-1:0]          out_bias,
    output logic                     err
);

    localparam int            CW   = (LAYER_SZ > 1) ? $clog2(LAYER_SZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(LAYER_SZ - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;

    // Ascending packed range: index 0 lands in the MSBs, which matches the
    // required element ordering without any index arithmetic.
    logic [0:LAYER_SZ-1][SIZE-1:0] col_w, col_x, nxt_w, nxt_x, ow_r, ox_r;
    logic [SIZE-1:0]               col_b, nxt_b;

    logic accept, is_last, early, store, done, slot_free, load;

    assign accept    = in_valid && in_ready;
    assign is_last   = (cnt == LAST);
    // An early in_last consumes the beat and drops the partial vector.
    assign early     = accept && in_last && !is_last;
    assign store     = accept && !early;
    assign done      = accept && is_last;
    assign slot_free = !out_valid || out_ready;
    // HOLD always has out_valid=1, so out_ready alone means a transfer there.
    assign load      = (state == FILL) ? (done && slot_free) : out_ready;

    // The collector contents as they will be after this edge. The output
    // slot loads from this so the final beat reaches it without an extra cycle.
    always_comb begin
        nxt_w = col_w;
        nxt_x = col_x;
        nxt_b = col_b;
        if (store) begin
            nxt_w[cnt] = in_weight;
            nxt_x[cnt] = in_input;
            if (cnt == '0) nxt_b = in_bias;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (done && !slot_free) state_nxt = HOLD;
            HOLD: if (out_ready)          state_nxt = FILL;
            default:                      state_nxt = FILL;
        endcase
    end

    // in_ready is taken straight from the state flop, so out_ready has
    // no combinational path to it.
    always_comb begin
        in_ready = (state == FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            col_w     <= '0;
            col_x     <= '0;
            col_b     <= '0;
            ow_r      <= '0;
            ox_r      <= '0;
            out_bias  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            col_w <= nxt_w;
            col_x <= nxt_x;
            col_b <= nxt_b;

            if (early || done) cnt <= '0;
            else if (store)    cnt <= cnt + 1'b1;

            if (early || (done && !in_last)) err <= 1'b1;

            if (load) begin
                ow_r      <= nxt_w;
                ox_r      <= nxt_x;
                out_bias  <= nxt_b;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_weights = ow_r;
    assign out_inputs  = ox_r;

endmodule

// File: tb/tb_fc_vector_loader.sv
// Testbench for fc_vector_loader (SIZE=16, LAYER_SZ=2).
// A directed table covers the basic, backpressure, early-last, missing-last
// and post-reset cases. A hand-written sequence covers the asynchronous reset
// in the middle of a fill. A streaming phase and a random phase are checked
// against a beat-level queue model.
module tb_fc_vector_loader;
    localparam int S = 16;
    localparam int L = 2;

    logic           clk, rst_n;
    logic           in_valid, in_ready, in_last, out_valid, out_ready, err;
    logic [S-1:0]   in_weight, in_input, in_bias, out_bias;
    logic [L*S-1:0] out_weights, out_inputs;

    fc_vector_loader #(.SIZE(S), .LAYER_SZ(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_weight(in_weight), .in_input(in_input), .in_bias(in_bias),
        .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_weights(out_weights), .out_inputs(out_inputs), .out_bias(out_bias),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic           v;
        logic [S-1:0]   w, x, b;
        logic           lst, ordy;
        logic           e_ir, e_ov;
        logic [L*S-1:0] e_ow, e_ox;
        logic [S-1:0]   e_ob;
        logic           e_err;
    } row_t;

    row_t rows[14];

    function automatic row_t mk(logic v, logic [S-1:0] w, logic [S-1:0] x, logic [S-1:0] b,
                                logic lst, logic ordy, logic ir, logic ov,
                                logic [L*S-1:0] ow, logic [L*S-1:0] ox, logic [S-1:0] ob,
                                logic e);
        row_t r;
        r.v = v; r.w = w; r.x = x; r.b = b; r.lst = lst; r.ordy = ordy;
        r.e_ir = ir; r.e_ov = ov; r.e_ow = ow; r.e_ox = ox; r.e_ob = ob; r.e_err = e;
        return r;
    endfunction

    // Each row drives one cycle and checks the outputs just after the edge.
    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            in_valid = rows[i].v; in_weight = rows[i].w; in_input = rows[i].x;
            in_bias = rows[i].b; in_last = rows[i].lst; out_ready = rows[i].ordy;
            @(posedge clk); #1;
            chk($sformatf("row%0d_in_ready", i),  in_ready,    rows[i].e_ir);
            chk($sformatf("row%0d_out_valid", i), out_valid,   rows[i].e_ov);
            chk($sformatf("row%0d_weights", i),   out_weights, rows[i].e_ow);
            chk($sformatf("row%0d_inputs", i),    out_inputs,  rows[i].e_ox);
            chk($sformatf("row%0d_bias", i),      out_bias,    rows[i].e_ob);
            chk($sformatf("row%0d_err", i),       err,         rows[i].e_err);
        end
    endtask

    task automatic do_reset();
        in_valid = 0; out_ready = 0; in_last = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
    endtask

    // Beat-level reference model: the element count, the partial vector and
    // the expected vectors in order.
    int              mcnt;
    logic [S-1:0]    mw[L], mx[L], mb;
    logic [80-1:0]   expq[$];
    logic            merr;
    logic            hold_prev;
    logic [80-1:0]   held;
    int              xfers;

    task automatic model_clear();
        mcnt = 0; merr = 0; hold_prev = 0; xfers = 0;
        expq.delete();
    endtask

    // mode 0: random, 1: full-rate streaming, 2: drain
    task automatic rand_cycle(input int mode);
        logic acc, xf;
        if (mode == 2) begin
            in_valid = 0; out_ready = 1;
        end else begin
            in_valid  = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            out_ready = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
            in_weight = S'($urandom); in_input = S'($urandom); in_bias = S'($urandom);
            in_last   = (mcnt == L - 1);
            if (mode == 0 && $urandom_range(0, 9) == 0) in_last = !in_last;
        end
        if (mode == 1) chk("stream_in_ready", in_ready, 1'b1);
        chk("rand_err", err, merr);
        if (hold_prev)
            chk("hold_stable", {out_valid, out_weights, out_inputs, out_bias}, {1'b1, held});
        acc = in_valid && in_ready;
        xf  = out_valid && out_ready;
        if (xf) begin
            xfers++;
            chk("rand_q_nonempty", expq.size() != 0, 1'b1);
            if (expq.size() != 0) chk("rand_vec", {out_weights, out_inputs, out_bias}, expq.pop_front());
        end
        hold_prev = out_valid && !out_ready;
        held = {out_weights, out_inputs, out_bias};
        if (acc) begin
            if (in_last && mcnt < L - 1) begin
                merr = 1; mcnt = 0;
            end else begin
                mw[mcnt] = in_weight; mx[mcnt] = in_input;
                if (mcnt == 0) mb = in_bias;
                if (mcnt == L - 1) begin
                    if (!in_last) merr = 1;
                    expq.push_back({mw[0], mw[1], mx[0], mx[1], mb});
                    mcnt = 0;
                end else mcnt++;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rows[0]  = mk(1, 'h0800, 'h0800, 'h0800, 0, 1, 1, 0, 0, 0, 0, 0);
        rows[1]  = mk(1, 'h0800, 'h0800, 'hFFFF, 1, 1, 1, 1, 'h08000800, 'h08000800, 'h0800, 0);
        rows[2]  = mk(1, 'h0800, 'h1800, 'h0C00, 0, 0, 1, 1, 'h08000800, 'h08000800, 'h0800, 0);
        rows[3]  = mk(1, 'h0400, 'h2000, 'hFFFF, 1, 0, 0, 1, 'h08000800, 'h08000800, 'h0800, 0);
        rows[4]  = mk(0, 'h0000, 'h0000, 'h0000, 0, 0, 0, 1, 'h08000800, 'h08000800, 'h0800, 0);
        rows[5]  = mk(0, 'h0000, 'h0000, 'h0000, 0, 1, 1, 1, 'h08000400, 'h18002000, 'h0C00, 0);
        rows[6]  = mk(0, 'h0000, 'h0000, 'h0000, 0, 1, 1, 0, 'h08000400, 'h18002000, 'h0C00, 0);
        rows[7]  = mk(1, 'h0400, 'h0400, 'h0400, 1, 1, 1, 0, 'h08000400, 'h18002000, 'h0C00, 1);
        rows[8]  = mk(1, 'h0800, 'h0800, 'h0800, 0, 1, 1, 0, 'h08000400, 'h18002000, 'h0C00, 1);
        rows[9]  = mk(1, 'h0800, 'h0800, 'hFFFF, 1, 1, 1, 1, 'h08000800, 'h08000800, 'h0800, 1);
        rows[10] = mk(1, 'hAAAA, 'hCCCC, 'hEEEE, 0, 1, 1, 0, 0, 0, 0, 0);
        rows[11] = mk(1, 'hBBBB, 'hDDDD, 'h0000, 1, 1, 1, 1, 'hAAAABBBB, 'hCCCCDDDD, 'hEEEE, 0);
        rows[12] = mk(1, 'h1234, 'h9ABC, 'h1357, 0, 1, 1, 0, 'hAAAABBBB, 'hCCCCDDDD, 'hEEEE, 0);
        rows[13] = mk(1, 'h5678, 'hDEF0, 'hFFFF, 0, 1, 1, 1, 'h12345678, 'h9ABCDEF0, 'h1357, 1);

        rst_n = 0; in_valid = 0; out_ready = 0; in_last = 0;
        in_weight = 0; in_input = 0; in_bias = 0;
        #12;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_data", {out_weights, out_inputs, out_bias}, 80'h0);
        chk("reset_err", err, 1'b0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        // basic vector, backpressure/HOLD, early last
        run_rows(0, 9);

        // one accepted beat, then an asynchronous reset between clock edges
        in_valid = 1; in_weight = 'h1111; in_input = 'h2222; in_bias = 'h3333;
        in_last = 0; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_in_ready", in_ready, 1'b1);
        chk("async_rst_data", {out_weights, out_inputs, out_bias}, 80'h0);
        chk("async_rst_err", err, 1'b0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        // fresh vector after reset, then a vector missing its last marker
        run_rows(10, 13);

        // full-rate streaming: 4 vectors in 8 beats, the 4th drains on cycle 9
        do_reset();
        model_clear();
        for (int i = 0; i < 9; i++) rand_cycle(1);
        chk("stream_xfers", xfers, 4);

        // random traffic with framing errors and backpressure
        do_reset();
        model_clear();
        for (int i = 0; i < 1500; i++) rand_cycle(0);
        for (int i = 0; i < 6; i++) rand_cycle(2);
        chk("rand_queue_drained", expq.size(), 0);
        chk("rand_final_err", err, merr);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checked", passed, total);
        $fatal(1);
    end
endmodule
